// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: six-condition branch resolver with a per-PC bimodal
// predictor (2-bit saturating counters, no tags) and optional perf counters.
// Optional feature macro: BP_PERF_CNT_EN (enables br_count / mispred_count;
// when undefined both outputs are tied to zero and no counter state exists).
module branch_predict_resolve #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [2:0]        branch_type,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              res_pred_taken,
    output logic              branch_taken,
    output logic              mispredict,
    output logic [PERF_W-1:0] br_count,
    output logic [PERF_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [2:0] {
        BR_NONE  = 3'b000,
        BR_BEQZ  = 3'b001,
        BR_BNEQZ = 3'b010,
        BR_BEQ   = 3'b011,
        BR_BNE   = 3'b100,
        BR_BLTZ  = 3'b101,
        BR_BGEZ  = 3'b110,
        BR_RSVD  = 3'b111
    } br_type_e;

    br_type_e         br_type;
    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             cond_true;
    logic             legal;
    logic             update;
    logic [1:0]       cur_ctr;
    logic [1:0]       next_ctr;
    logic             unused_pc_bits;

    assign br_type  = br_type_e'(branch_type);
    // word-aligned PCs: bits [1:0] and everything above the index are not used
    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc, res_pc};

    // Condition evaluation from branch type, independent of res_valid
    always_comb begin
        cond_true = 1'b0;
        case (br_type)
            BR_BEQZ:  cond_true = (A == '0);
            BR_BNEQZ: cond_true = (A != '0);
            BR_BEQ:   cond_true = (A == B);
            BR_BNE:   cond_true = (A != B);
            BR_BLTZ:  cond_true = A[DATA_W-1];
            BR_BGEZ:  cond_true = ~A[DATA_W-1];
            default:  cond_true = 1'b0;
        endcase
    end

    assign legal  = res_valid && (br_type != BR_NONE) && (br_type != BR_RSVD);
    assign update = legal && !rst;

    assign branch_taken = cond_true && !rst;
    assign mispredict   = update && (cond_true != res_pred_taken);
    // read-before-write: lookup sees the table as it stands before this edge
    assign pred_taken   = bht[pred_idx][1] && !rst;

    // Saturating next value for the entry being trained
    always_comb begin
        cur_ctr  = bht[res_idx];
        next_ctr = cur_ctr;
        if (cond_true && cur_ctr != 2'b11) begin
            next_ctr = cur_ctr + 2'b01;
        end else if (!cond_true && cur_ctr != 2'b00) begin
            next_ctr = cur_ctr - 2'b01;
        end
    end

    // Predictor table: reset to weak-NT, train only the indexed entry
    always_ff @(posedge clk) begin
        if (rst) begin
            bht <= '{default: 2'b01};
        end else if (update) begin
            bht[res_idx] <= next_ctr;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [PERF_W-1:0] br_cnt_q;
    logic [PERF_W-1:0] mis_cnt_q;

    // Saturating performance counters for resolved and mispredicted branches
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (update && br_cnt_q != '1) begin
                br_cnt_q <= br_cnt_q + 1'b1;
            end
            if (mispredict && mis_cnt_q != '1) begin
                mis_cnt_q <= mis_cnt_q + 1'b1;
            end
        end
    end

    assign br_count      = br_cnt_q;
    assign mispred_count = mis_cnt_q;
`else
    assign br_count      = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Testbench for branch_predict_resolve: directed scenarios plus random traffic,
// checked per cycle by a scoreboard against an integer-level reference model.
module tb_branch_predict_resolve;

    localparam int PERF_W = 4;
    localparam int PERF_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       pred_pc = '0;
    logic              pred_taken;
    logic              res_valid = 1'b0;
    logic [31:0]       res_pc = '0;
    logic [2:0]        branch_type = '0;
    logic [31:0]       A = '0;
    logic [31:0]       B = '0;
    logic              res_pred_taken = 1'b0;
    logic              branch_taken;
    logic              mispredict;
    logic [PERF_W-1:0] br_count;
    logic [PERF_W-1:0] mispred_count;

    branch_predict_resolve #(
        .DATA_W(32),
        .PC_W(32),
        .BHT_DEPTH(16),
        .PERF_W(PERF_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pred_pc(pred_pc),
        .pred_taken(pred_taken),
        .res_valid(res_valid),
        .res_pc(res_pc),
        .branch_type(branch_type),
        .A(A),
        .B(B),
        .res_pred_taken(res_pred_taken),
        .branch_taken(branch_taken),
        .mispredict(mispredict),
        .br_count(br_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  id;
        bit  pred;
        bit  taken;
        bit  mis;
        int  bc;
        int  mc;
        bit  chk_cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // reference model state: plain integer counters 0..3 per entry
    int   m_bht[16];
    int   m_br = 0;
    int   m_mis = 0;
    int   cyc = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit cond_of(input int t, input logic [31:0] a, input logic [31:0] b);
        case (t)
            1: return a == 0;
            2: return a != 0;
            3: return a == b;
            4: return a != b;
            5: return $signed(a) < 0;
            6: return $signed(a) >= 0;
            default: return 0;
        endcase
    endfunction

    // one cycle of stimulus: drive, predict outputs, advance model
    task automatic step(input bit r, input logic [31:0] ppc, input bit rv,
                        input logic [31:0] rpc, input int t,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit rpt, input bit chk_cnt);
        exp_t e;
        bit   c;
        bit   lg;
        int   ri;
        @(posedge clk);
        #1;
        rst = r; pred_pc = ppc; res_valid = rv; res_pc = rpc;
        branch_type = 3'(t); A = a; B = b; res_pred_taken = rpt;
        c  = cond_of(t, a, b);
        lg = rv && t >= 1 && t <= 6;
        ri = idx_of(rpc);
        e.id = cyc;
        e.chk_cnt = chk_cnt;
`ifdef BP_PERF_CNT_EN
        e.bc = m_br;
        e.mc = m_mis;
`else
        e.bc = 0;
        e.mc = 0;
`endif
        if (r) begin
            e.pred = 0; e.taken = 0; e.mis = 0;
            foreach (m_bht[i]) m_bht[i] = 1;
            m_br = 0; m_mis = 0;
        end else begin
            e.pred  = m_bht[idx_of(ppc)] >= 2;
            e.taken = c;
            e.mis   = lg && (c != rpt);
            if (lg) begin
                if (c) m_bht[ri] = (m_bht[ri] < 3) ? m_bht[ri] + 1 : 3;
                else   m_bht[ri] = (m_bht[ri] > 0) ? m_bht[ri] - 1 : 0;
                if (m_br < PERF_MAX) m_br++;
                if (e.mis && m_mis < PERF_MAX) m_mis++;
            end
        end
        q.push_back(e);
        cyc++;
    endtask

    task automatic idle(input logic [31:0] ppc);
        step(0, ppc, 0, 32'h0, 0, 0, 0, 0, 1);
    endtask

    task automatic resolve(input logic [31:0] ppc, input logic [31:0] rpc, input int t,
                           input logic [31:0] a, input logic [31:0] b, input bit rpt);
        step(0, ppc, 1, rpc, t, a, b, rpt, 1);
    endtask

    task automatic cmp(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents one set of outputs mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp("pred_taken", e.id, int'(pred_taken), int'(e.pred));
            cmp("branch_taken", e.id, int'(branch_taken), int'(e.taken));
            cmp("mispredict", e.id, int'(mispredict), int'(e.mis));
            if (e.chk_cnt) begin
                cmp("br_count", e.id, int'(br_count), e.bc);
                cmp("mispred_count", e.id, int'(mispred_count), e.mc);
            end
        end
    end

    initial begin
        logic [31:0] pcs [8];
        logic [31:0] vals [6];
        int          t;
        pcs  = '{32'h10, 32'h50, 32'h40, 32'h80, 32'h14, 32'h93, 32'h3C, 32'h100};
        vals = '{32'h0, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

        // reset (counts unknown before the first edge)
`ifdef BP_PERF_CNT_EN
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
`else
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 1);
`endif
        step(1, 32'h40, 0, 0, 0, 0, 0, 0, 1);

        // first lookup predicts NT; BEQ taken mispredicts; entry becomes weak-T
        idle(32'h40);
        resolve(32'h40, 32'h40, 3, 32'd5, 32'd5, 0);
        idle(32'h40);

        // condition sweep with A = all ones, B = 0, including illegal types
        for (int i = 0; i < 8; i++) resolve(32'h204, 32'h204, i, 32'hFFFF_FFFF, 32'h0, 0);
        idle(32'h204);

        // saturation walk at 0x80
        for (int i = 0; i < 4; i++) resolve(32'h80, 32'h80, 3, 32'd1, 32'd1, 1);
        for (int i = 0; i < 5; i++) resolve(32'h80, 32'h80, 4, 32'd1, 32'd1, 1);
        idle(32'h80);

        // same-cycle read-before-write and aliasing of 0x10 / 0x50
        resolve(32'h10, 32'h10, 1, 32'h0, 32'h0, 0);
        idle(32'h10);
        idle(32'h50);

        // perf counters: 20 legal branches, 3 mispredicts
        step(1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) resolve(32'h300, 32'h300, 3, 32'd7, 32'd7, i >= 3);
        idle(32'h300);

        // reset with a concurrent legal resolve is ignored
        step(1, 32'h10, 1, 32'h10, 1, 32'h0, 32'h0, 0, 1);
        idle(32'h10);
        idle(32'h10);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            t = int'($urandom_range(0, 7));
            step(($urandom_range(0, 60) == 0),
                 pcs[$urandom_range(0, 7)],
                 ($urandom_range(0, 3) != 0),
                 pcs[$urandom_range(0, 7)],
                 t,
                 vals[$urandom_range(0, 5)],
                 vals[$urandom_range(0, 5)],
                 1'($urandom_range(0, 1)),
                 1);
        end
        done = 1;
    end

    // End of run: drain the scoreboard within a bounded number of cycles
    initial begin
        wait (done);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d outputs never observed, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
